// File: rtl/lsu_pkg.sv
// Shared types and RV32 width codes for the load/store unit.
// Holds the FSM state type and funct3 decode helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(
    input logic       store,
    input logic [2:0] f3
  );
    if (store)
      return (f3 == F3_B) || (f3 == F3_H) ||
             (f3 == F3_W);
    return (f3 == F3_B)  || (f3 == F3_H)  ||
           (f3 == F3_W)  || (f3 == F3_BU) ||
           (f3 == F3_HU);
  endfunction

  // Access size in bytes; only meaningful for legal codes.
  function automatic logic [2:0] f3_size(
    input logic [2:0] f3
  );
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: lane masks, store shifting and load
// extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rd_lo,
  input  logic [31:0] i_rd_hi,
  output logic        o_split,
  output logic [3:0]  o_mask_lo,
  output logic [3:0]  o_mask_hi,
  output logic [31:0] o_wdata_lo,
  output logic [31:0] o_wdata_hi,
  output logic [31:0] o_rdata
);

  logic [2:0]  w_size;
  logic [3:0]  w_mask_n;
  logic [7:0]  w_mask8;
  logic [4:0]  w_sh;
  logic [63:0] w_wd64;
  logic [63:0] w_rd_pair;
  logic [31:0] w_rd_sh;

  assign w_size = f3_size(i_funct3);
  assign w_sh   = {i_off, 3'b000};

  always_comb begin
    w_mask_n = 4'b1111;
    unique case (1'b1)
      (w_size == 3'd1): w_mask_n = 4'b0001;
      (w_size == 3'd2): w_mask_n = 4'b0011;
      default:          w_mask_n = 4'b1111;
    endcase
  end

  // Upper halves of the 8-lane / 64-bit shifts spill into the next word.
  assign w_mask8    = {4'b0000, w_mask_n} << i_off;
  assign o_mask_lo  = w_mask8[3:0];
  assign o_mask_hi  = w_mask8[7:4];
  assign w_wd64     = {32'h0, i_wdata} << w_sh;
  assign o_wdata_lo = w_wd64[31:0];
  assign o_wdata_hi = w_wd64[63:32];
  assign o_split    = ({1'b0, i_off} + w_size) > 3'd4;

  assign w_rd_pair = {i_rd_hi, i_rd_lo};
  assign w_rd_sh   = w_rd_pair[w_sh +: 32];

  always_comb begin
    o_rdata = w_rd_sh;
    unique case (1'b1)
      (i_funct3 == F3_B):
        o_rdata = {{24{w_rd_sh[7]}}, w_rd_sh[7:0]};
      (i_funct3 == F3_BU):
        o_rdata = {24'h0, w_rd_sh[7:0]};
      (i_funct3 == F3_H):
        o_rdata = {{16{w_rd_sh[15]}}, w_rd_sh[15:0]};
      (i_funct3 == F3_HU):
        o_rdata = {16'h0, w_rd_sh[15:0]};
      default:
        o_rdata = w_rd_sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit: one or two word accesses per request,
// registered memory port, one-cycle response pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_store,
  input  logic [2:0]    req_funct3,
  input  logic [AW+1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_data,
  output logic          rsp_err,
  output logic          cs,
  output logic          wr,
  output logic [3:0]    mask,
  output logic [AW-1:0] addr,
  output logic [31:0]   data_wr,
  input  logic [31:0]   data_rd
);

  lsu_state_e    r_state;
  logic          r_store;
  logic [2:0]    r_f3;
  logic [AW-1:0] r_word;
  logic [1:0]    r_off;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rd_a;
  logic          r_cs;
  logic          r_wr;
  logic [3:0]    r_mask;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_data_wr;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [31:0]   r_rsp_data;

  logic          w_idle;
  logic          w_acc2;
  logic          w_legal;
  logic [2:0]    w_f3;
  logic [1:0]    w_off;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rd_lo;
  logic [31:0]   w_rd_hi;
  logic          w_split;
  logic [3:0]    w_mask_lo;
  logic [3:0]    w_mask_hi;
  logic [31:0]   w_wdata_lo;
  logic [31:0]   w_wdata_hi;
  logic [31:0]   w_rdata;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_acc2  = (r_state == ST_ACC2);
  assign w_legal = f3_legal(req_store, req_funct3);

  // In IDLE the aligner sees the incoming request so ACC1 outputs
  // can be registered at the accept edge.
  assign w_f3    = w_idle ? req_funct3     : r_f3;
  assign w_off   = w_idle ? req_addr[1:0]  : r_off;
  assign w_wdata = w_idle ? req_wdata      : r_wdata;
  assign w_rd_lo = w_acc2 ? r_rd_a         : data_rd;
  assign w_rd_hi = w_acc2 ? data_rd        : 32'h0;

  lsu_align u_align (
    .i_funct3   (w_f3),
    .i_off      (w_off),
    .i_wdata    (w_wdata),
    .i_rd_lo    (w_rd_lo),
    .i_rd_hi    (w_rd_hi),
    .o_split    (w_split),
    .o_mask_lo  (w_mask_lo),
    .o_mask_hi  (w_mask_hi),
    .o_wdata_lo (w_wdata_lo),
    .o_wdata_hi (w_wdata_hi),
    .o_rdata    (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_store     <= 1'b0;
      r_f3        <= 3'b000;
      r_word      <= '0;
      r_off       <= 2'b00;
      r_wdata     <= 32'h0;
      r_rd_a      <= 32'h0;
      r_cs        <= 1'b1;
      r_wr        <= 1'b1;
      r_mask      <= 4'h0;
      r_addr      <= '0;
      r_data_wr   <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= 32'h0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= 32'h0;
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid && w_legal) begin
            r_state   <= ST_ACC1;
            r_store   <= req_store;
            r_f3      <= req_funct3;
            r_word    <= req_addr[AW+1:2];
            r_off     <= req_addr[1:0];
            r_wdata   <= req_wdata;
            r_cs      <= 1'b0;
            r_wr      <= ~req_store;
            r_addr    <= req_addr[AW+1:2];
            r_mask    <= w_mask_lo;
            r_data_wr <= w_wdata_lo;
          end else if (req_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
          end
        end
        ST_ACC1: begin
          r_rd_a <= data_rd;
          if (w_split) begin
            r_state   <= ST_ACC2;
            r_addr    <= r_word + 1'b1;
            r_mask    <= w_mask_hi;
            r_data_wr <= w_wdata_hi;
          end else begin
            r_state     <= ST_IDLE;
            r_cs        <= 1'b1;
            r_wr        <= 1'b1;
            r_mask      <= 4'h0;
            r_addr      <= '0;
            r_data_wr   <= 32'h0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_store ? 32'h0 : w_rdata;
          end
        end
        ST_ACC2: begin
          r_state     <= ST_IDLE;
          r_cs        <= 1'b1;
          r_wr        <= 1'b1;
          r_mask      <= 4'h0;
          r_addr      <= '0;
          r_data_wr   <= 32'h0;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= r_store ? 32'h0 : w_rdata;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = w_idle;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;
  assign cs        = r_cs;
  assign wr        = r_wr;
  assign mask      = r_mask;
  assign addr      = r_addr;
  assign data_wr   = r_data_wr;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-lane memory
// model written on the falling clock edge.
module tb_load_store_unit;

  localparam int AW = 20;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_store;
  logic [2:0]    req_funct3;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic          cs;
  logic          wr;
  logic [3:0]    mask;
  logic [AW-1:0] addr;
  logic [31:0]   data_wr;
  logic [31:0]   data_rd;

  logic [31:0] mem [0:(1<<AW)-1];

  int checks;
  int errors;

  load_store_unit #(.AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .cs         (cs),
    .wr         (wr),
    .mask       (mask),
    .addr       (addr),
    .data_wr    (data_wr),
    .data_rd    (data_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_rd = mem[addr];

  always @(negedge clk) begin
    if (!cs && !wr) begin
      for (int i = 0; i < 4; i++)
        if (mask[i]) mem[addr][8*i +: 8] <= data_wr[8*i +: 8];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; returns 1 ns after it.
  task automatic issue(
    input logic          st,
    input logic [2:0]    f3,
    input logic [AW+1:0] a,
    input logic [31:0]   wd
  );
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", req_ready);
    end
    checks++;
    if ({cs, wr, mask} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 110000", {cs, wr, mask});
    end
    checks++;
    if (addr !== '0 || data_wr !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got %h/%h exp 0/0", addr, data_wr);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== 34'h0) begin
      errors++;
      $display("FAIL reset_rsp got %b/%b/%h exp 0", rsp_valid, rsp_err, rsp_data);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_sw_aligned();
    mem[20'h40] = 32'h0;
    issue(1'b1, 3'b010, 22'h100, 32'h11223344);
    checks++;
    if ({cs, wr, mask} !== 6'b001111 || addr !== 20'h40) begin
      errors++;
      $display("FAIL sw_acc1 got %b/%h exp 001111/00040", {cs, wr, mask}, addr);
    end
    checks++;
    if (data_wr !== 32'h11223344 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL sw_data got %h/%b/%b exp 11223344/0/0", data_wr, rsp_valid, req_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h0 || cs !== 1'b1) begin
      errors++;
      $display("FAIL sw_rsp got %b/%b/%h/%b exp 1/0/0/1", rsp_valid, rsp_err, rsp_data, cs);
    end
    checks++;
    if (mem[20'h40] !== 32'h11223344) begin
      errors++;
      $display("FAIL sw_mem got %h exp 11223344", mem[20'h40]);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sw_pulse got %b exp 0", rsp_valid);
    end
  endtask

  task automatic test_loads();
    logic [2:0]    f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010};
    logic [AW+1:0] as  [6] = '{22'h102, 22'h103, 22'h100, 22'h102, 22'h102, 22'h100};
    logic [3:0]    ms  [6] = '{4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1100, 4'b1111};
    logic [31:0]   exp [6] = '{32'hFFFFFFFF, 32'h00000080, 32'h00007F01,
                               32'h000080FF, 32'hFFFF80FF, 32'h80FF7F01};
    mem[20'h40] = 32'h80FF7F01;
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, f3s[i], as[i], 32'hDEADBEEF);
      checks++;
      if ({cs, wr, mask} !== {2'b01, ms[i]} || addr !== 20'h40) begin
        errors++;
        $display("FAIL ld%0d_acc got %b/%h exp %b/00040", i, {cs, wr, mask}, addr, {2'b01, ms[i]});
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp[i] || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL ld%0d_rsp got %b/%h exp 1/%h", i, rsp_valid, rsp_data, exp[i]);
      end
    end
    step();
  endtask

  task automatic test_split();
    mem[20'h40] = 32'h0;
    mem[20'h41] = 32'h0;
    issue(1'b1, 3'b010, 22'h103, 32'hAABBCCDD);
    checks++;
    if ({cs, wr, mask} !== 6'b001000 || addr !== 20'h40 || data_wr !== 32'hDD000000) begin
      errors++;
      $display("FAIL split_acc1 got %b/%h/%h exp 001000/00040/dd000000", {cs, wr, mask}, addr, data_wr);
    end
    step();
    checks++;
    if ({cs, wr, mask} !== 6'b000111 || addr !== 20'h41 || data_wr !== 32'h00AABBCC || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL split_acc2 got %b/%h/%h/%b exp 000111/00041/00aabbcc/0", {cs, wr, mask}, addr, data_wr, rsp_valid);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || cs !== 1'b1 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL split_rsp got %b/%b/%h exp 1/1/0", rsp_valid, cs, rsp_data);
    end
    checks++;
    if (mem[20'h40] !== 32'hDD000000 || mem[20'h41] !== 32'h00AABBCC) begin
      errors++;
      $display("FAIL split_mem got %h/%h exp dd000000/00aabbcc", mem[20'h40], mem[20'h41]);
    end
    issue(1'b0, 3'b001, 22'h103, 32'h0);
    step();
    checks++;
    if (rsp_valid !== 1'b0 || addr !== 20'h41 || mask !== 4'b0001) begin
      errors++;
      $display("FAIL split_lh_acc2 got %b/%h/%b exp 0/00041/0001", rsp_valid, addr, mask);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFFCCDD) begin
      errors++;
      $display("FAIL split_lh_rsp got %b/%h exp 1/ffffccdd", rsp_valid, rsp_data);
    end
    step();
  endtask

  task automatic test_wrap();
    mem[20'hFFFFF] = 32'h12345678;
    mem[20'h00000] = 32'h9ABCDEF0;
    issue(1'b0, 3'b010, 22'h3FFFFE, 32'h0);
    checks++;
    if (addr !== 20'hFFFFF || mask !== 4'b1100) begin
      errors++;
      $display("FAIL wrap_acc1 got %h/%b exp fffff/1100", addr, mask);
    end
    step();
    checks++;
    if (addr !== 20'h00000 || mask !== 4'b0011 || cs !== 1'b0) begin
      errors++;
      $display("FAIL wrap_acc2 got %h/%b/%b exp 00000/0011/0", addr, mask, cs);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEF01234) begin
      errors++;
      $display("FAIL wrap_rsp got %b/%h exp 1/def01234", rsp_valid, rsp_data);
    end
    step();
  endtask

  task automatic test_illegal();
    logic          sts [3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0]    f3s [3] = '{3'b011, 3'b111, 3'b100};
    for (int i = 0; i < 3; i++) begin
      issue(sts[i], f3s[i], 22'h100, 32'h12345678);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
        errors++;
        $display("FAIL ill%0d_rsp got %b/%b/%h exp 1/1/0", i, rsp_valid, rsp_err, rsp_data);
      end
      checks++;
      if (cs !== 1'b1 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL ill%0d_idle got %b/%b exp 1/1", i, cs, req_ready);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL ill%0d_pulse got %b/%b exp 0/0", i, rsp_valid, rsp_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    mem[20'h40] = 32'h0;
    mem[20'h41] = 32'h0;
    issue(1'b1, 3'b010, 22'h103, 32'h55667788);
    checks++;
    if (cs !== 1'b0) begin
      errors++;
      $display("FAIL rmid_acc1 got %b exp 0", cs);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({cs, wr, mask} !== 6'b110000 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async got %b/%b/%b exp 110000/1/0", {cs, wr, mask}, req_ready, rsp_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      seen |= rsp_valid | ~cs;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      seen |= rsp_valid | ~cs;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rmid_quiet got %b exp 0", seen);
    end
    checks++;
    if (mem[20'h40] !== 32'h0 || mem[20'h41] !== 32'h0) begin
      errors++;
      $display("FAIL rmid_mem got %h/%h exp 0/0", mem[20'h40], mem[20'h41]);
    end
    issue(1'b1, 3'b010, 22'h200, 32'hCAFEBABE);
    step();
    checks++;
    if (rsp_valid !== 1'b1 || mem[20'h80] !== 32'hCAFEBABE) begin
      errors++;
      $display("FAIL rmid_after got %b/%h exp 1/cafebabe", rsp_valid, mem[20'h80]);
    end
    step();
  endtask

  task automatic test_back_to_back();
    mem[20'h10] = 32'h01020304;
    mem[20'h11] = 32'hA0B0C0D0;
    issue(1'b0, 3'b010, 22'h40, 32'h0);
    step();
    checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b1 || rsp_data !== 32'h01020304) begin
      errors++;
      $display("FAIL b2b_first got %b/%b/%h exp 1/1/01020304", rsp_valid, req_ready, rsp_data);
    end
    issue(1'b0, 3'b010, 22'h44, 32'h0);
    checks++;
    if (cs !== 1'b0 || addr !== 20'h11) begin
      errors++;
      $display("FAIL b2b_accept got %b/%h exp 0/00011", cs, addr);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hA0B0C0D0) begin
      errors++;
      $display("FAIL b2b_second got %b/%h exp 1/a0b0c0d0", rsp_valid, rsp_data);
    end
    step();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = 32'h0;
    #1;
    test_reset();
    test_sw_aligned();
    test_loads();
    test_split();
    test_wrap();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter AW, default 20, word-address width of the data memory port.
REQ-002 SHALL have port clk  input  1  single clock for all state; memory samples writes on its falling edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  pipeline presents a load/store.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_store  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32 width code: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
REQ-008 SHALL have port req_addr  input  AW+2  byte address; [AW+1:2] word, [1:0] offset.
REQ-009 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_data  output  32  extended load result; 0 for stores and errors.
REQ-012 SHALL have port rsp_err  output  1  illegal funct3, valid with rsp_valid.
REQ-013 SHALL have ports cs (output 1, active-low), wr (output 1, 0 = write, 1 = read), mask (output 4, byte lanes), addr (output AW, word), data_wr (output 32), data_rd (input 32, combinational read data).

Function
REQ-014 SHALL drive req_ready = 1 only in state IDLE; handshake completes on a rising edge with req_valid & req_ready; all request fields are captured then.
REQ-015 SHALL implement states IDLE, ACC1, ACC2: IDLE->ACC1 on a legal accept; ACC1->ACC2 when offset + size > 4; otherwise ACC1->IDLE; ACC2->IDLE.
REQ-016 SHALL, on an illegal funct3 (load 011/110/111, store >= 011), stay in IDLE, make no memory access, and pulse rsp_valid = 1, rsp_err = 1 on the next cycle.
REQ-017 SHALL drive all memory outputs from registers, stable across the falling edge; idle values: cs = 1, wr = 1, mask = 0, addr = 0, data_wr = 0.
REQ-018 SHALL, in ACC1, drive cs = 0, wr = ~req_store, addr = word, mask = (2^n - 1) << off truncated to 4 bits (n = 1, 2 or 4 bytes), data_wr = wdata << 8*off.
REQ-019 SHALL, in ACC2, drive addr = word + 1 mod 2^AW (0xFFFFF wraps to 0x00000), mask = (2^n - 1) >> (4 - off), data_wr = wdata >> 8*(4 - off).
REQ-020 SHALL, for loads, register data_rd at the end of each access cycle.
REQ-021 SHALL form the load result as low n bytes of {rdB, rdA} >> 8*off, sign-extended for LB/LH, zero-extended for LBU/LHU.
REQ-022 SHALL pulse rsp_valid for exactly one cycle after the last access: latency from accept is 2 cycles aligned, 3 cycles split; stores also complete with rsp_data = 0.
REQ-023 SHALL allow a new request to be accepted in the same cycle rsp_valid is high (back-to-back throughput 1 access per 2 cycles aligned).

Reset
REQ-024 SHALL, on rst = 0 at any time including mid-ACC1/ACC2, immediately enter IDLE with req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_data = 0 and idle memory outputs; an interrupted access produces no response.

Structure
REQ-025 SHALL take the state enum and funct3 width codes from a shared package lsu_pkg.
REQ-026 SHALL place lane-mask, store-shift and load-extract/extend logic in one combinational sub-module lsu_align.

Verification
REQ-027 SW 0x11223344 to byte 0x100 -> one cycle cs = 0, wr = 0, addr = 0x40, mask = 1111; rsp_valid 2 cycles after accept.
REQ-028 Word 0x40 = 0x80FF7F01; LB @0x102 -> 0xFFFFFFFF; LBU @0x103 -> 0x00000080; LH @0x100 -> 0x00007F01.
REQ-029 SW 0xAABBCCDD @0x103 -> ACC1 addr 0x40 mask 1000 data_wr 0xDD000000, ACC2 addr 0x41 mask 0111 data_wr 0x00AABBCC; rsp_valid 3 cycles after accept.
REQ-030 LW @ byte 0x3FFFFE -> ACC2 addr wraps to 0x00000; result = {word0[15:0], word0xFFFFF[31:16]}.
REQ-031 Load with funct3 011 -> no cs assertion, next cycle rsp_valid = 1, rsp_err = 1, rsp_data = 0.
REQ-032 rst low during ACC1 of a split store -> cs = 1 immediately, no ACC2, no rsp_valid; next request after release behaves normally.
